pipeline_sequencer: RTL and testbench

Central stall/flush controller for the five-stage MIPS pipeline. Each cycle it decides, per pipeline register (IF_ID, ID_EX, EX_MEM, MEM_WB), whether to load, hold or bubble, and whether the PC advances. It resolves load-use hazards, taken-branch flushes, multi-cycle data-memory waits and halt draining. It also keeps a saturating stall counter and a sticky memory-timeout error.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/hazard_detect.sv | 19 +
 rtl/pipeline_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_pipeline_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the five-stage pipeline: sequencer states and
// pipeline register indices used by the sequencer and the register modules.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } seq_state_t;

  // Pipeline register indices; pwrite/phold bit N controls register N.
  localparam int IF_ID  = 1;
  localparam int ID_EX  = 2;
  localparam int EX_MEM = 3;
  localparam int MEM_WB = 4;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags when the load in EX writes a register that the
// instruction in ID reads. Register 0 is hardwired zero and never hazards.
module hazard_detect (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_dest,
  input  logic       ex_memread,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit   = (ex_dest == id_rs);
  assign rt_hit   = id_uses_rt && (ex_dest == id_rt);
  assign load_use = ex_memread && (ex_dest != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush controller for the five-stage pipeline. Decides each cycle
// whether each pipeline register loads, holds or bubbles and whether the PC
// advances. State updates on the falling clock edge, matching the pipeline
// registers; control outputs are combinational so hazards respond in the
// same cycle.
module pipeline_sequencer
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 64,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_dest,
  input  logic        ex_memread,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        pc_write,
  output logic        pwrite1,
  output logic        pwrite2,
  output logic        pwrite3,
  output logic        pwrite4,
  output logic        phold1,
  output logic        phold2,
  output logic        phold3,
  output logic        halted,
  output logic        mem_error,
  output logic [15:0] stall_count
);

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  seq_state_t         state;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               load_use;
  logic               mem_stall;
  logic               pc_w;
  logic [4:1]         pw;
  logic [3:1]         ph;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  hazard_detect u_hazard (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_dest    (ex_dest),
    .ex_memread (ex_memread),
    .load_use   (load_use)
  );

  assign mem_stall = mem_req && !mem_ready;

  // Output mux: per-state control with RUN priority mem wait > branch > halt > load-use.
  always_comb begin
    pc_w = 1'b1;
    pw   = 4'b1111;
    ph   = 3'b000;
    case (state)
      RUN: begin
        if (mem_stall) begin
          pc_w       = 1'b0;
          ph         = 3'b111;
          pw[MEM_WB] = 1'b0;
        end else if (ex_branch_taken) begin
          pw[IF_ID] = 1'b0;
          pw[ID_EX] = 1'b0;
        end else if (halt_req) begin
          pc_w      = 1'b0;
          pw[IF_ID] = 1'b0;
        end else if (load_use) begin
          pc_w      = 1'b0;
          ph[IF_ID] = 1'b1;
          pw[ID_EX] = 1'b0;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          if (ex_branch_taken) begin
            pw[IF_ID] = 1'b0;
            pw[ID_EX] = 1'b0;
          end
        end else begin
          pc_w       = 1'b0;
          ph         = 3'b111;
          pw[MEM_WB] = 1'b0;
        end
      end
      DRAIN: begin
        pc_w = 1'b0;
        if (mem_stall) begin
          ph         = 3'b111;
          pw[MEM_WB] = 1'b0;
        end else begin
          pw[IF_ID] = 1'b0;
        end
      end
      HALTED: begin
        pc_w = 1'b0;
        pw   = 4'b0000;
      end
      default: begin
        pc_w = 1'b0;
        pw   = 4'b0000;
      end
    endcase
    if (!reset_n) begin
      pc_w = 1'b0;
      pw   = 4'b0000;
      ph   = 3'b000;
    end
  end

  assign pc_write = pc_w;
  assign pwrite1  = pw[IF_ID];
  assign pwrite2  = pw[ID_EX];
  assign pwrite3  = pw[EX_MEM];
  assign pwrite4  = pw[MEM_WB];
  assign phold1   = ph[IF_ID];
  assign phold2   = ph[ID_EX];
  assign phold3   = ph[EX_MEM];
  assign halted   = (state == HALTED);

  // FSM, wait/drain counters, sticky timeout error and saturating stall counter.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      drain_cnt   <= '0;
      mem_error   <= 1'b0;
      stall_count <= 16'd0;
    end else begin
      if (state != HALTED && !pc_w) begin
        stall_count <= sat_inc(stall_count);
      end
      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end else if (!ex_branch_taken && halt_req) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_LIMIT) begin
            mem_error <= 1'b1;
            state     <= HALTED;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DRAIN: begin
          // A memory wait freezes the pipe, so those cycles do not drain it.
          if (!mem_stall) begin
            if (drain_cnt == DRAIN_LAST) begin
              state <= HALTED;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: directed vector table, multi-cycle corner
// sequences and random stimulus against a behavioural model.
module tb_pipeline_sequencer;

  localparam int MEM_TIMEOUT  = 64;
  localparam int DRAIN_CYCLES = 3;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic [4:0] dest;
    logic       memread;
    logic       br;
    logic       mreq;
    logic       mrdy;
    logic       halt;
  } in_t;

  typedef struct packed {
    logic        pc;
    logic [3:0]  pw;   // {pwrite1, pwrite2, pwrite3, pwrite4}
    logic [2:0]  ph;   // {phold1, phold2, phold3}
    logic        halted;
    logic        err;
    logic [15:0] stall;
  } out_t;

  typedef struct {
    string name;
    in_t   stim;
    out_t  exp;
  } row_t;

  logic        clk;
  logic        reset_n;
  logic [4:0]  id_rs, id_rt, ex_dest;
  logic        id_uses_rt, ex_memread, ex_branch_taken;
  logic        mem_req, mem_ready, halt_req;
  logic        pc_write, pwrite1, pwrite2, pwrite3, pwrite4;
  logic        phold1, phold2, phold3, halted, mem_error;
  logic [15:0] stall_count;

  int vectors;
  int miscompares;

  // Behavioural model state
  bit m_halted;
  bit m_err;
  int m_wait;        // cycles spent waiting on memory so far, 0 when not waiting
  int m_drain_left;  // drain cycles still owed, 0 when not draining
  int m_stalls;

  pipeline_sequencer #(
    .MEM_TIMEOUT  (MEM_TIMEOUT),
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_dest         (ex_dest),
    .ex_memread      (ex_memread),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .halt_req        (halt_req),
    .pc_write        (pc_write),
    .pwrite1         (pwrite1),
    .pwrite2         (pwrite2),
    .pwrite3         (pwrite3),
    .pwrite4         (pwrite4),
    .phold1          (phold1),
    .phold2          (phold2),
    .phold3          (phold3),
    .halted          (halted),
    .mem_error       (mem_error),
    .stall_count     (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic in_t mk_in(input int rs, input int rt, input bit ur, input int dest,
                                input bit mr, input bit br, input bit mq, input bit my,
                                input bit h);
    in_t i;
    i.rs = 5'(rs); i.rt = 5'(rt); i.uses_rt = ur; i.dest = 5'(dest);
    i.memread = mr; i.br = br; i.mreq = mq; i.mrdy = my; i.halt = h;
    return i;
  endfunction

  function automatic out_t mk_out(input bit pc, input logic [3:0] pw, input logic [2:0] ph,
                                  input bit h, input bit e, input int st);
    out_t o;
    o.pc = pc; o.pw = pw; o.ph = ph; o.halted = h; o.err = e; o.stall = 16'(st);
    return o;
  endfunction

  function automatic out_t get_act();
    out_t o;
    o.pc     = pc_write;
    o.pw     = {pwrite1, pwrite2, pwrite3, pwrite4};
    o.ph     = {phold1, phold2, phold3};
    o.halted = halted;
    o.err    = mem_error;
    o.stall  = stall_count;
    return o;
  endfunction

  // Expected outputs for this cycle from the current model state and inputs.
  function automatic out_t model_out(input in_t i);
    out_t o;
    bit   mstall;
    bit   lu;
    mstall = i.mreq && !i.mrdy;
    lu = i.memread && (i.dest != 0) &&
         ((i.dest == i.rs) || (i.uses_rt && (i.dest == i.rt)));
    o = mk_out(1'b1, 4'b1111, 3'b000, m_halted, m_err, m_stalls);
    if (m_halted) begin
      o.pc = 1'b0; o.pw = 4'b0000;
    end else if (m_wait > 0) begin
      if (!i.mrdy) begin
        o.pc = 1'b0; o.ph = 3'b111; o.pw = 4'b1110;
      end else if (i.br) begin
        o.pw = 4'b0011;
      end
    end else if (m_drain_left > 0) begin
      o.pc = 1'b0;
      if (mstall) begin
        o.ph = 3'b111; o.pw = 4'b1110;
      end else begin
        o.pw = 4'b0111;
      end
    end else if (mstall) begin
      o.pc = 1'b0; o.ph = 3'b111; o.pw = 4'b1110;
    end else if (i.br) begin
      o.pw = 4'b0011;
    end else if (i.halt) begin
      o.pc = 1'b0; o.pw = 4'b0111;
    end else if (lu) begin
      o.pc = 1'b0; o.ph = 3'b100; o.pw = 4'b1011;
    end
    return o;
  endfunction

  // Advance the model across one active clock edge.
  task automatic model_update(input in_t i, input out_t o);
    bit mstall;
    mstall = i.mreq && !i.mrdy;
    if (!m_halted && !o.pc && m_stalls < 65535) m_stalls++;
    if (m_halted) begin
      // stays halted until reset
    end else if (m_wait > 0) begin
      if (i.mrdy) m_wait = 0;
      else if (m_wait == MEM_TIMEOUT) begin
        m_wait = 0; m_halted = 1; m_err = 1;
      end else m_wait++;
    end else if (m_drain_left > 0) begin
      if (!mstall) begin
        m_drain_left--;
        if (m_drain_left == 0) m_halted = 1;
      end
    end else if (mstall) begin
      m_wait = 1;
    end else if (!i.br && i.halt) begin
      m_drain_left = DRAIN_CYCLES;
    end
  endtask

  task automatic model_reset();
    m_halted = 0; m_err = 0; m_wait = 0; m_drain_left = 0; m_stalls = 0;
  endtask

  task automatic compare(input string name, input out_t act, input out_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got pc=%b pw=%b ph=%b halted=%b err=%b stall=%0d, expected pc=%b pw=%b ph=%b halted=%b err=%b stall=%0d",
               name, act.pc, act.pw, act.ph, act.halted, act.err, act.stall,
               exp.pc, exp.pw, exp.ph, exp.halted, exp.err, exp.stall);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input in_t i);
    id_rs = i.rs; id_rt = i.rt; id_uses_rt = i.uses_rt; ex_dest = i.dest;
    ex_memread = i.memread; ex_branch_taken = i.br;
    mem_req = i.mreq; mem_ready = i.mrdy; halt_req = i.halt;
  endtask

  // One pipeline cycle: drive after the rising edge, check, let the falling edge act.
  task automatic step(input in_t i, input string name, input bit use_tbl, input out_t texp);
    out_t mexp;
    @(posedge clk);
    #1 drive(i);
    #1;
    mexp = model_out(i);
    compare(name, get_act(), use_tbl ? texp : mexp);
    @(negedge clk);
    #1;
    model_update(i, mexp);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 compare("reset_forced", get_act(), '0);
    drive('0);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  row_t tbl[$];

  initial begin
    in_t  idle;
    in_t  r;
    int   k;
    int   halted_cycles;

    vectors = 0;
    miscompares = 0;
    idle = '0;
    reset_n = 1'b0;
    drive(idle);
    model_reset();

    //            name          rs rt ur dst mr br mq my h      pc pw       ph      h  e  stall
    tbl.push_back('{"idle",      mk_in(0,0,0,0,0,0,0,0,0), mk_out(1,4'b1111,3'b000,0,0,0)});
    tbl.push_back('{"lu_rs",     mk_in(8,0,0,8,1,0,0,0,0), mk_out(0,4'b1011,3'b100,0,0,0)});
    tbl.push_back('{"after_lu",  mk_in(0,0,0,0,0,0,0,0,0), mk_out(1,4'b1111,3'b000,0,0,1)});
    tbl.push_back('{"lu_rt",     mk_in(3,9,1,9,1,0,0,0,0), mk_out(0,4'b1011,3'b100,0,0,1)});
    tbl.push_back('{"rt_unused", mk_in(3,9,0,9,1,0,0,0,0), mk_out(1,4'b1111,3'b000,0,0,2)});
    tbl.push_back('{"lu_zero",   mk_in(0,0,1,0,1,0,0,0,0), mk_out(1,4'b1111,3'b000,0,0,2)});
    tbl.push_back('{"no_load",   mk_in(8,8,1,8,0,0,0,0,0), mk_out(1,4'b1111,3'b000,0,0,2)});
    tbl.push_back('{"lu_branch", mk_in(8,0,0,8,1,1,0,0,0), mk_out(1,4'b0011,3'b000,0,0,2)});
    tbl.push_back('{"branch",    mk_in(0,0,0,0,0,1,0,0,0), mk_out(1,4'b0011,3'b000,0,0,2)});
    tbl.push_back('{"mwait1",    mk_in(0,0,0,0,0,0,1,0,0), mk_out(0,4'b1110,3'b111,0,0,2)});
    tbl.push_back('{"mwait2",    mk_in(0,0,0,0,0,0,1,0,0), mk_out(0,4'b1110,3'b111,0,0,3)});
    tbl.push_back('{"mwait3",    mk_in(0,0,0,0,0,0,1,0,0), mk_out(0,4'b1110,3'b111,0,0,4)});
    tbl.push_back('{"mrelease",  mk_in(0,0,0,0,0,0,1,1,0), mk_out(1,4'b1111,3'b000,0,0,5)});
    tbl.push_back('{"post_mem",  mk_in(0,0,0,0,0,0,0,0,0), mk_out(1,4'b1111,3'b000,0,0,5)});
    tbl.push_back('{"mem_fast",  mk_in(0,0,0,0,0,0,1,1,0), mk_out(1,4'b1111,3'b000,0,0,5)});
    tbl.push_back('{"mem_vs_br", mk_in(0,0,0,0,0,1,1,0,0), mk_out(0,4'b1110,3'b111,0,0,5)});
    tbl.push_back('{"rel_br",    mk_in(0,0,0,0,0,1,1,1,0), mk_out(1,4'b0011,3'b000,0,0,6)});
    tbl.push_back('{"br_vs_hlt", mk_in(0,0,0,0,0,1,0,0,1), mk_out(1,4'b0011,3'b000,0,0,6)});
    tbl.push_back('{"halt_lu",   mk_in(8,0,0,8,1,0,0,0,1), mk_out(0,4'b0111,3'b000,0,0,6)});
    tbl.push_back('{"drain1",    mk_in(0,0,0,0,0,0,0,0,0), mk_out(0,4'b0111,3'b000,0,0,7)});
    tbl.push_back('{"drain2",    mk_in(0,0,0,0,0,0,0,0,0), mk_out(0,4'b0111,3'b000,0,0,8)});
    tbl.push_back('{"drain3",    mk_in(0,0,0,0,0,0,0,0,0), mk_out(0,4'b0111,3'b000,0,0,9)});
    tbl.push_back('{"halted",    mk_in(0,0,0,0,0,0,0,0,0), mk_out(0,4'b0000,3'b000,1,0,10)});
    tbl.push_back('{"halt_stay", mk_in(8,0,0,8,1,0,1,0,1), mk_out(0,4'b0000,3'b000,1,0,10)});

    // Initial reset
    #3 compare("reset_forced_init", get_act(), '0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    foreach (tbl[n]) step(tbl[n].stim, tbl[n].name, 1'b1, tbl[n].exp);

    // Memory wait during drain extends the drain by the wait length.
    do_reset();
    step(mk_in(0,0,0,0,0,0,0,0,1), "drain_halt", 1'b0, '0);
    k = 0;
    while (!halted && k < 30) begin
      r = (k == 1 || k == 2) ? mk_in(0,0,0,0,0,0,1,0,0) : idle;
      step(r, "drain_mem", 1'b0, '0);
      k++;
    end
    check_int("drain_ext_cycles", k, DRAIN_CYCLES + 2);

    // Memory timeout: HALTED exactly MEM_TIMEOUT cycles after entering MEM_WAIT.
    do_reset();
    r = mk_in(0,0,0,0,0,0,1,0,0);
    step(r, "tmo_enter", 1'b0, '0);
    k = 0;
    while (!halted && k < 200) begin
      step(r, "tmo_wait", 1'b0, '0);
      k++;
    end
    check_int("timeout_cycles", k, MEM_TIMEOUT);
    for (int j = 0; j < 5; j++) step(mk_in(0,0,0,0,0,0,1,1,0), "tmo_sticky", 1'b0, '0);
    check_int("tmo_err_sticky", int'(mem_error), 1);
    do_reset();
    step(idle, "post_tmo_reset", 1'b0, '0);

    // Reset in the middle of a memory wait.
    do_reset();
    for (int j = 0; j < 3; j++) step(mk_in(0,0,0,0,0,0,1,0,0), "pre_rst_wait", 1'b0, '0);
    do_reset();
    step(idle, "rst_wait_run", 1'b0, '0);
    step(mk_in(0,0,0,0,0,0,1,1,0), "rst_wait_noready", 1'b0, '0);

    // Randomised traffic against the model.
    do_reset();
    halted_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      if (m_halted) halted_cycles++;
      else halted_cycles = 0;
      if (halted_cycles > 2) begin
        do_reset();
        halted_cycles = 0;
      end
      r.rs      = 5'($urandom_range(0, 3));
      r.rt      = 5'($urandom_range(0, 3));
      r.uses_rt = 1'($urandom_range(0, 1));
      r.dest    = 5'($urandom_range(0, 3));
      r.memread = ($urandom_range(0, 2) == 0);
      r.br      = ($urandom_range(0, 5) == 0);
      r.mreq    = ($urandom_range(0, 3) == 0);
      r.mrdy    = 1'($urandom_range(0, 1));
      r.halt    = ($urandom_range(0, 59) == 0);
      step(r, "random", 1'b0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
